// File: rtl/forwarding_check_logic_ctl.sv
// Operand-forwarding select and load-use stall detector for one source operand.
// Optional macro FWD_STATS_EN adds saturating fwd_cnt/stall_cnt hazard statistics.
module forwarding_check_logic_ctl #(
  parameter int ADDR_W = 4,
  parameter logic [ADDR_W-1:0] NO_FWD = {ADDR_W{1'b1}}
`ifdef FWD_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] in_add,
  input  logic [ADDR_W-1:0] m_add1,
  input  logic [ADDR_W-1:0] m_add2,
  input  logic [ADDR_W-1:0] m_add3,
  input  logic              v1,
  input  logic              v2,
  input  logic              v3,
  input  logic              load,
  output logic [1:0]        mux_sel,
  output logic              stall
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  logic       addr_ok;
  logic       m1;
  logic       m2;
  logic       m3;
  logic [1:0] sel_raw;

  assign addr_ok = (in_add != NO_FWD);
  assign m1      = v1 & (m_add1 == in_add) & addr_ok;
  assign m2      = v2 & (m_add2 == in_add) & addr_ok;
  assign m3      = v3 & (m_add3 == in_add) & addr_ok;

  // Youngest stage wins; a load-use match still selects EX while the stall holds it off.
  assign sel_raw = m1 ? 2'b01 :
                   m2 ? 2'b10 :
                   m3 ? 2'b11 : 2'b00;

  // Outputs are forced quiet while reset is held, independent of the clock.
  assign mux_sel = {2{rst_n}} & sel_raw;
  assign stall   = rst_n & load & m1;

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] fwd_cnt_q;
  logic [CNT_W-1:0] fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    if (en && (cnt != {CNT_W{1'b1}}))
      return cnt + CNT_W'(1);
    return cnt;
  endfunction

  always_comb begin
    fwd_cnt_d   = sat_inc(fwd_cnt_q, (mux_sel != 2'b00) & ~stall);
    stall_cnt_d = sat_inc(stall_cnt_q, stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt   = fwd_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_clk;
  assign unused_clk = clk;
`endif

endmodule

// File: tb/tb_forwarding_check_logic_ctl.sv
// Directed and swept stimulus for forwarding_check_logic_ctl with a rule-level model
// checked every cycle; define FWD_STATS_EN to also cover the statistic counters.
module tb_forwarding_check_logic_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_add = 4'd3;
  logic [3:0] m_add1 = 4'd3;
  logic [3:0] m_add2 = 4'd0;
  logic [3:0] m_add3 = 4'd0;
  logic       v1 = 1'b1;
  logic       v2 = 1'b0;
  logic       v3 = 1'b0;
  logic       load = 1'b1;
  logic [1:0] mux_sel;
  logic       stall;
`ifdef FWD_STATS_EN
  logic [15:0] fwd_cnt;
  logic [15:0] stall_cnt;
  int          exp_fwd_cnt = 0;
  int          exp_stall_cnt = 0;
`endif

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  forwarding_check_logic_ctl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_add   (in_add),
    .m_add1   (m_add1),
    .m_add2   (m_add2),
    .m_add3   (m_add3),
    .v1       (v1),
    .v2       (v2),
    .v3       (v3),
    .load     (load),
    .mux_sel  (mux_sel)
`ifdef FWD_STATS_EN
    ,
    .stall    (stall),
    .fwd_cnt  (fwd_cnt),
    .stall_cnt(stall_cnt)
`else
    ,
    .stall    (stall)
`endif
  );

  // Rule-level model: scan stages youngest-first for the first valid match.
  function automatic void model(output int sel, output int st);
    int  dst[3];
    bit  vld[3];
    dst[0] = int'(m_add1); dst[1] = int'(m_add2); dst[2] = int'(m_add3);
    vld[0] = v1;           vld[1] = v2;           vld[2] = v3;
    sel = 0;
    st  = 0;
    if (rst_n !== 1'b1) return;
    if (in_add == 4'd15) return;
    for (int s = 0; s < 3; s++) begin
      if (vld[s] && dst[s] == int'(in_add)) begin
        sel = s + 1;
        break;
      end
    end
    if (load && sel == 1) st = 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req)
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    else
      passed++;
  endtask

`ifdef FWD_STATS_EN
  always @(posedge clk or negedge rst_n) begin
    int s, t;
    if (!rst_n) begin
      exp_fwd_cnt   = 0;
      exp_stall_cnt = 0;
    end else begin
      model(s, t);
      if (s != 0 && t == 0 && exp_fwd_cnt < 65535) exp_fwd_cnt++;
      if (t == 1 && exp_stall_cnt < 65535) exp_stall_cnt++;
    end
  end
`endif

  always @(negedge clk) begin
    int s, t;
    if (chk_en) begin
      model(s, t);
      check("model_mux_sel", 32'(mux_sel), 32'(s));
      check("model_stall", 32'(stall), 32'(t));
`ifdef FWD_STATS_EN
      check("model_fwd_cnt", 32'(fwd_cnt), 32'(exp_fwd_cnt));
      check("model_stall_cnt", 32'(stall_cnt), 32'(exp_stall_cnt));
`endif
    end
  end

  task automatic apply(input logic [3:0] i, a1, a2, a3,
                       input logic vv1, vv2, vv3, ld);
    @(posedge clk);
    #1;
    in_add = i; m_add1 = a1; m_add2 = a2; m_add3 = a3;
    v1 = vv1; v2 = vv2; v3 = vv3; load = ld;
  endtask

  typedef struct {
    logic [3:0] i, a1, a2, a3;
    logic       vv1, vv2, vv3, ld;
    logic [1:0] sel;
    logic       st;
  } vec_t;

  vec_t vecs[12] = '{
    '{4'd3,  4'd8,  4'd9, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0},
    '{4'd3,  4'd8,  4'd3, 4'd11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0},
    '{4'd3,  4'd8,  4'd6, 4'd3,  1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0},
    '{4'd3,  4'd3,  4'd6, 4'd11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1},
    '{4'd3,  4'd3,  4'd3, 4'd11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1},
    '{4'd3,  4'd3,  4'd3, 4'd3,  1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1},
    '{4'd3,  4'd8,  4'd3, 4'd3,  1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0},
    '{4'd15, 4'd15, 4'd0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0},
    '{4'd3,  4'd3,  4'd3, 4'd3,  1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0},
    '{4'd3,  4'd3,  4'd6, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0},
    '{4'd3,  4'd3,  4'd3, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0},
    '{4'd0,  4'd0,  4'd0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1}
  };

  initial begin
    // Reset held with an EX load-use match on the inputs.
    @(negedge clk);
    check("reset_mux_sel", 32'(mux_sel), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    #2 rst_n = 1'b1;

    for (int k = 0; k < 12; k++) begin
      apply(vecs[k].i, vecs[k].a1, vecs[k].a2, vecs[k].a3,
            vecs[k].vv1, vecs[k].vv2, vecs[k].vv3, vecs[k].ld);
      @(negedge clk);
      check($sformatf("vec%0d_mux_sel", k), 32'(mux_sel), 32'(vecs[k].sel));
      check($sformatf("vec%0d_stall", k), 32'(stall), 32'(vecs[k].st));
    end

    // Asynchronous reset mid-cycle with a load-use hazard present.
    apply(4'd5, 4'd5, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_mux_sel", 32'(mux_sel), 32'h0);
    check("async_reset_stall", 32'(stall), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("release_mux_sel", 32'(mux_sel), 32'h1);
    check("release_stall", 32'(stall), 32'h1);

    for (int k = 0; k < 300; k++) begin
      logic [3:0] pick[5];
      pick[0] = 4'($urandom_range(0, 3));
      pick[1] = 4'($urandom_range(0, 3));
      pick[2] = 4'($urandom_range(0, 3));
      pick[3] = 4'($urandom_range(0, 3));
      pick[4] = 4'($urandom_range(0, 7));
      if (pick[4] == 4'd7) pick[0] = 4'd15;
      apply(pick[0], pick[1], pick[2], pick[3], 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef FWD_STATS_EN
    apply(4'd3, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("cnt_reset_fwd", 32'(fwd_cnt), 32'h0);
    check("cnt_reset_stall", 32'(stall_cnt), 32'h0);
    #2 rst_n = 1'b1;
    repeat (3) apply(4'd3, 4'd8, 4'd3, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) apply(4'd3, 4'd3, 4'd6, 4'd11, 1'b1, 1'b1, 1'b1, 1'b1);
    apply(4'd3, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("cnt_fwd_three", 32'(fwd_cnt), 32'd3);
    check("cnt_stall_two", 32'(stall_cnt), 32'd2);

    apply(4'd3, 4'd8, 4'd8, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    check("cnt_fwd_saturate", 32'(fwd_cnt), 32'h0000FFFF);
    check("cnt_stall_hold", 32'(stall_cnt), 32'd2);
`endif

    // Unknown addresses must not reach stall while load is low.
    apply(4'd3, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    in_add = 4'bxxxx;
    m_add1 = 4'bxxxx;
    #2;
    check("x_addr_stall", 32'(stall), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
